wb_stage: RTL and testbench

WB_STAGE -- requirements
Module: wb_stage

---
 rtl/wb_stage.sv | 91 +++++++++
 tb/tb_wb_stage.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/wb_stage.sv
// Writeback stage: holds one finished instruction, writes the register file on retire
// and counts retirements. Define WB_FWD_EN to drive the forwarding bus from the held instruction.
module wb_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid,
    input  logic        mem_wen,
    input  logic [4:0]  mem_dest,
    input  logic [31:0] mem_result,
    input  logic [31:0] mem_pc,
    input  logic        wb_stall,
    output logic        wb_allowin,
    output logic        wb_valid,
    output logic [31:0] wb_pc,
    output logic        rf_wen,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic [4:0]  wb_dest,
    output logic        fwd_valid,
    output logic [4:0]  fwd_dest,
    output logic [31:0] fwd_data,
    output logic [31:0] retire_cnt
);

    logic        valid_q, valid_d;
    logic        wen_q, wen_d;
    logic [4:0]  dest_q, dest_d;
    logic [31:0] result_q, result_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] retire_cnt_q, retire_cnt_d;
    logic        wb_over;
    logic        load;
    logic        dest_nz;

    always_comb begin
        wb_over      = valid_q & ~wb_stall;
        wb_allowin   = ~valid_q | wb_over;
        load         = mem_valid & wb_allowin;
        dest_nz      = (dest_q != 5'd0);
        valid_d      = wb_allowin ? mem_valid : valid_q;
        wen_d        = wen_q;
        dest_d       = dest_q;
        result_d     = result_q;
        pc_d         = pc_q;
        if (load) begin
            wen_d    = mem_wen;
            dest_d   = mem_dest;
            result_d = mem_result;
            pc_d     = mem_pc;
        end
        retire_cnt_d = wb_over ? retire_cnt_q + 32'd1 : retire_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q      <= 1'b0;
            wen_q        <= 1'b0;
            dest_q       <= 5'd0;
            result_q     <= 32'd0;
            pc_q         <= 32'd0;
            retire_cnt_q <= 32'd0;
        end else begin
            valid_q      <= valid_d;
            wen_q        <= wen_d;
            dest_q       <= dest_d;
            result_q     <= result_d;
            pc_q         <= pc_d;
            retire_cnt_q <= retire_cnt_d;
        end
    end

    // Reset discards the held instruction, so a retire coinciding with rst must not write.
    assign rf_wen     = wb_over & wen_q & dest_nz & ~rst;
    assign rf_waddr   = dest_q;
    assign rf_wdata   = result_q;
    assign wb_valid   = valid_q;
    assign wb_pc      = pc_q;
    assign wb_dest    = (valid_q & wen_q) ? dest_q : 5'd0;
    assign retire_cnt = retire_cnt_q;

`ifdef WB_FWD_EN
    assign fwd_valid  = valid_q & wen_q & dest_nz;
    assign fwd_dest   = dest_q;
    assign fwd_data   = result_q;
`else
    assign fwd_valid  = 1'b0;
    assign fwd_dest   = 5'd0;
    assign fwd_data   = 32'd0;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Testbench for wb_stage: directed scenarios plus random traffic, checked against a
// one-slot stage model and a scoreboard of expected register-file writes.
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_valid;
    logic        mem_wen;
    logic [4:0]  mem_dest;
    logic [31:0] mem_result;
    logic [31:0] mem_pc;
    logic        wb_stall;
    logic        wb_allowin;
    logic        wb_valid;
    logic [31:0] wb_pc;
    logic        rf_wen;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [4:0]  wb_dest;
    logic        fwd_valid;
    logic [4:0]  fwd_dest;
    logic [31:0] fwd_data;
    logic [31:0] retire_cnt;

    wb_stage dut (
        .clk(clk), .rst(rst),
        .mem_valid(mem_valid), .mem_wen(mem_wen), .mem_dest(mem_dest),
        .mem_result(mem_result), .mem_pc(mem_pc), .wb_stall(wb_stall),
        .wb_allowin(wb_allowin), .wb_valid(wb_valid), .wb_pc(wb_pc),
        .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .wb_dest(wb_dest), .fwd_valid(fwd_valid), .fwd_dest(fwd_dest),
        .fwd_data(fwd_data), .retire_cnt(retire_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  dest;
        logic [31:0] data;
    } wr_t;

    wr_t         exp_q[$];
    int          check_cnt = 0;
    int          pass_cnt  = 0;

    // Reference model: the stage is a single slot that is either empty or holds one instruction.
    bit          m_occ;
    bit          m_wen;
    logic [4:0]  m_dest;
    logic [31:0] m_res;
    logic [31:0] m_pc;
    logic [31:0] m_cnt;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        check_cnt++;
        if (act === exp) pass_cnt++;
        else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    task automatic modelReset;
        m_occ = 0; m_wen = 0; m_dest = '0; m_res = '0; m_pc = '0; m_cnt = '0;
    endtask

    task automatic checkOutput;
        bit          retire;
        bit          writes;
        logic [4:0]  exp_wb_dest;
        retire      = m_occ && !wb_stall;
        writes      = !rst && retire && m_wen && (m_dest != 0);
        exp_wb_dest = (m_occ && m_wen) ? m_dest : 5'd0;
        cmp("wb_valid",   {31'd0, wb_valid},   {31'd0, m_occ});
        cmp("wb_allowin", {31'd0, wb_allowin}, {31'd0, !m_occ || retire});
        cmp("rf_wen",     {31'd0, rf_wen},     {31'd0, writes});
        cmp("wb_dest",    {27'd0, wb_dest},    {27'd0, exp_wb_dest});
        cmp("retire_cnt", retire_cnt,          m_cnt);
        cmp("wb_pc",      wb_pc,               m_pc);
`ifdef WB_FWD_EN
        cmp("fwd_valid",  {31'd0, fwd_valid},  {31'd0, m_occ && m_wen && (m_dest != 0)});
        cmp("fwd_dest",   {27'd0, fwd_dest},   {27'd0, m_dest});
        cmp("fwd_data",   fwd_data,            m_res);
`else
        cmp("fwd_valid",  {31'd0, fwd_valid},  32'd0);
        cmp("fwd_dest",   {27'd0, fwd_dest},   32'd0);
        cmp("fwd_data",   fwd_data,            32'd0);
`endif
        if (writes) exp_q.push_back('{dest: m_dest, data: m_res});
    endtask

    task automatic modelAdvance;
        bit retire;
        bit accept;
        if (rst) begin
            modelReset();
        end else begin
            retire = m_occ && !wb_stall;
            accept = mem_valid && (!m_occ || retire);
            if (retire) m_cnt = m_cnt + 32'd1;
            if (!m_occ || retire) m_occ = mem_valid;
            if (accept) begin
                m_wen = mem_wen; m_dest = mem_dest; m_res = mem_result; m_pc = mem_pc;
            end
        end
    endtask

    task automatic applyStimulus(input bit r, input bit v, input bit w, input logic [4:0] d,
                                 input logic [31:0] res, input bit s);
        @(negedge clk);
        rst = r; mem_valid = v; mem_wen = w; mem_dest = d; mem_result = res;
        mem_pc = $urandom; wb_stall = s;
        #1;
        checkOutput();
        modelAdvance();
    endtask

    // Monitor: every register-file write the DUT makes must match the oldest expected write.
    always @(negedge clk) begin
        #2;
        if (rf_wen === 1'b1) begin
            if (exp_q.size() == 0) begin
                cmp("unexpected_write", {27'd0, rf_waddr}, 32'hFFFF_FFFF);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                cmp("rf_waddr", {27'd0, rf_waddr}, {27'd0, e.dest});
                cmp("rf_wdata", rf_wdata, e.data);
            end
        end
    end

    initial begin
        rst = 1'b1; mem_valid = 0; mem_wen = 0; mem_dest = '0; mem_result = '0;
        mem_pc = '0; wb_stall = 0;
        modelReset();
        repeat (2) @(posedge clk);

        $display("[TB] reset and idle");
        applyStimulus(0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);

        $display("[TB] single write to r5");
        applyStimulus(0, 1, 1, 5, 32'h1234_5678, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);

        $display("[TB] write to r0 is suppressed but retires");
        applyStimulus(0, 1, 1, 0, 32'hDEAD_BEEF, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);

        $display("[TB] stall holds r7, next instruction waits");
        applyStimulus(0, 1, 1, 7, 32'h0000_0777, 0);
        for (int i = 0; i < 3; i++) applyStimulus(0, 1, 1, 8, 32'h0000_0888, 1);
        applyStimulus(0, 1, 1, 8, 32'h0000_0888, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 1);

        $display("[TB] back-to-back writes r1..r4");
        for (int i = 1; i <= 4; i++) applyStimulus(0, 1, 1, 5'(i), 32'hA000_0000 + i, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);

        $display("[TB] reset discards held r9");
        applyStimulus(0, 1, 1, 9, 32'h9999_0009, 0);
        applyStimulus(0, 0, 0, 0, 0, 1);
        applyStimulus(1, 1, 1, 10, 32'h1010_1010, 1);
        applyStimulus(0, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 1, 11, 32'h1111_0011, 0);
        applyStimulus(1, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);

        $display("[TB] random traffic");
        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom_range(0, 59) == 0),
                          ($urandom_range(0, 3) != 0),
                          ($urandom_range(0, 3) != 0),
                          ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom),
                          $urandom,
                          ($urandom_range(0, 3) == 0));
        end
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 0, 0);

        @(negedge clk);
        #3;
        cmp("pending_writes", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
